// File: rtl/audio_pkg.sv
// Shared audio-path types and constants: PCM sample type, default FIR geometry,
// the lowpass coefficient table and the FIR control state encoding.
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int DEFAULT_N_TAPS    = 16;
  localparam int DEFAULT_COEF_FRAC = 15;

  // Symmetric Q1.15 lowpass, all taps positive, sum = 32768 (unity DC gain).
  localparam sample_t LPF_COEFS [DEFAULT_N_TAPS] = '{
    16'sd300,  16'sd600,  16'sd1000, 16'sd1600,
    16'sd2200, 16'sd2900, 16'sd3600, 16'sd4184,
    16'sd4184, 16'sd3600, 16'sd2900, 16'sd2200,
    16'sd1600, 16'sd1000, 16'sd600,  16'sd300
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAC    = 2'd1,
    ST_ROUND  = 2'd2,
    ST_OUTPUT = 2'd3
  } fir_state_e;

  // Taps beyond the stored table read as zero so a longer filter stays well-defined.
  function automatic sample_t lpf_coef(input int idx);
    sample_t c;
    c = '0;
    if (idx >= 0 && idx < DEFAULT_N_TAPS) c = LPF_COEFS[idx];
    return c;
  endfunction

endpackage

// File: rtl/sample_round_sat.sv
// Round-half-up of a wide signed accumulator by FRAC fractional bits, then
// saturate to a 16-bit PCM sample. Purely combinational; shared with mixer stages.
module sample_round_sat
  import audio_pkg::*;
#(
  parameter int ACC_W = 36,
  parameter int FRAC  = 15
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output sample_t                 sample_o
);

  localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(1) <<< (FRAC-1);
  localparam logic signed [ACC_W:0] MAX_S = (ACC_W+1)'(32767);
  localparam logic signed [ACC_W:0] MIN_S = -(ACC_W+1)'(32768);

  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;

  // One guard bit so adding the half-LSB can never wrap.
  always_comb begin
    biased  = (ACC_W+1)'(acc_i) + HALF;
    shifted = biased >>> FRAC;
    if (shifted > MAX_S) begin
      sample_o = 16'sh7fff;
    end else if (shifted < MIN_S) begin
      sample_o = 16'sh8000;
    end else begin
      sample_o = shifted[15:0];
    end
  end

endmodule

// File: rtl/sample_lowpass_fir.sv
// Sequential single-MAC lowpass FIR inserted between volume_adjust and the audio
// output path. One product per clock over a circular history of N_TAPS samples.
module sample_lowpass_fir
  import audio_pkg::*;
#(
  parameter int N_TAPS    = DEFAULT_N_TAPS,
  parameter int COEF_FRAC = DEFAULT_COEF_FRAC
) (
  input  logic       clk,
  input  logic       rst,
  input  sample_t    in_sample,
  input  logic       in_valid,
  output logic       in_ready,
  output sample_t    out_sample,
  output logic       out_valid,
  output logic       overrun,
  input  logic       clear_overrun,
  output fir_state_e state_o
);

  localparam int IDX_W = $clog2(N_TAPS);
  localparam int ACC_W = 32 + IDX_W;

  // Handshake: a sample is taken on a rising clk edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and in_valid seen while in_ready is low is
  // dropped and flagged in the sticky overrun bit.

  fir_state_e              state_q;
  logic [IDX_W-1:0]        wp_q;
  logic [IDX_W-1:0]        tap_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  sample_t                 smp_q [N_TAPS];
  sample_t                 out_sample_q;
  logic                    out_valid_q;
  logic                    in_ready_q;
  logic                    overrun_q;

  logic                    accept;
  logic [IDX_W-1:0]        rd_idx;
  sample_t                 coef;
  logic signed [31:0]      prod;
  sample_t                 rounded;

  assign accept = in_valid && in_ready_q;

  // wp_q already points past the newest entry once MAC starts.
  always_comb begin
    rd_idx = wp_q - IDX_W'(1) - tap_q;
    coef   = lpf_coef(int'(tap_q));
    prod   = 32'(smp_q[rd_idx]) * 32'(coef);
    acc_d  = acc_q + ACC_W'(prod);
  end

  sample_round_sat #(
    .ACC_W (ACC_W),
    .FRAC  (COEF_FRAC)
  ) u_round_sat (
    .acc_i    (acc_q),
    .sample_o (rounded)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wp_q         <= '0;
      tap_q        <= '0;
      acc_q        <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      overrun_q    <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) smp_q[i] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      // Set wins over a simultaneous clear.
      if (clear_overrun) overrun_q <= 1'b0;
      if (in_valid && !in_ready_q) overrun_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            smp_q[wp_q] <= in_sample;
            wp_q        <= wp_q + IDX_W'(1);
            acc_q       <= '0;
            tap_q       <= '0;
            in_ready_q  <= 1'b0;
            state_q     <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_q <= acc_d;
          tap_q <= tap_q + IDX_W'(1);
          if (tap_q == IDX_W'(N_TAPS-1)) state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          out_sample_q <= rounded;
          out_valid_q  <= 1'b1;
          state_q      <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_sample_lowpass_fir.sv
// Bench for sample_lowpass_fir: impulse, DC, overrun, wrap, random and
// mid-MAC reset scenarios against a convolution model over the accepted history.
module tb_sample_lowpass_fir;
  import audio_pkg::*;

  localparam int NT  = 16;
  localparam int LAT = NT + 2;

  logic       clk = 1'b0;
  logic       rst;
  sample_t    in_sample;
  logic       in_valid;
  logic       in_ready;
  sample_t    out_sample;
  logic       out_valid;
  logic       overrun;
  logic       clear_overrun;
  fir_state_e state_o;

  int n_checks = 0;
  int n_errors = 0;

  int tb_coef [NT] = '{300, 600, 1000, 1600, 2200, 2900, 3600, 4184,
                       4184, 3600, 2900, 2200, 1600, 1000, 600, 300};

  logic signed [15:0] hist  [$];
  logic signed [15:0] exp_q [$];

  sample_lowpass_fir #(.N_TAPS(NT), .COEF_FRAC(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_sample     (in_sample),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_sample    (out_sample),
    .out_valid     (out_valid),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .state_o       (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: direct convolution of the accepted history with the tap table,
  // missing history counts as zero; round half up then clamp to 16 bits.
  function automatic logic signed [15:0] model_out();
    longint acc;
    int     n;
    acc = 0;
    n   = hist.size();
    for (int i = 0; i < NT; i++)
      if (n - 1 - i >= 0) acc += longint'(hist[n-1-i]) * longint'(tb_coef[i]);
    acc = (acc + 16384) >>> 15;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("ready_timeout", 32'(in_ready), 1);
  endtask

  // Sends one sample, optionally pulses in_valid (and clear_overrun) at cycle
  // pulse_at after the accept, and checks handshake timing plus the result.
  task automatic send_sample(input logic signed [15:0] s, input int pulse_at,
                             input bit pulse_clr, output logic signed [15:0] got);
    int first_v, n_v, n_low;
    logic signed [15:0] e;
    repeat ($urandom_range(0, 4)) @(negedge clk);
    wait_ready();
    in_sample = s;
    in_valid  = 1'b1;
    hist.push_back(s);
    exp_q.push_back(model_out());
    first_v = -1; n_v = 0; n_low = 0; got = '0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid  = 1'b0;
        in_sample = '0;
      end
      if (pulse_at > 0 && k == pulse_at + 1) begin
        in_valid      = 1'b0;
        clear_overrun = 1'b0;
      end
      if (!in_ready) n_low++;
      if (out_valid) begin
        n_v++;
        if (first_v < 0) begin
          first_v = k;
          got     = out_sample;
        end
      end
      if (pulse_at > 0 && k == pulse_at) begin
        in_valid      = 1'b1;
        in_sample     = 16'($urandom_range(0, 65535));
        clear_overrun = pulse_clr;
      end
    end
    check_eq("out_valid_cycle", first_v, LAT);
    check_eq("out_valid_width", n_v, 1);
    check_eq("in_ready_low", n_low, LAT);
    e = exp_q.pop_front();
    check_eq("out_sample", got, e);
  endtask

  task automatic run_impulse(input string tag);
    logic signed [15:0] got;
    for (int k = 0; k < NT; k++) begin
      send_sample((k == 0) ? -16'sd32768 : 16'sd0, -1, 1'b0, got);
      check_eq(tag, got, -tb_coef[k]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic signed [15:0] got;
    int n_v;

    rst = 1'b1; in_valid = 1'b0; in_sample = '0; clear_overrun = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 1);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_sample", out_sample, 0);
    check_eq("rst_overrun", 32'(overrun), 0);
    check_eq("rst_state", 32'(state_o), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    run_impulse("impulse");

    for (int i = 0; i < 32; i++) begin
      send_sample(16'sd32767, -1, 1'b0, got);
      if (i >= NT - 1) check_eq("dc_pos", got, 32767);
    end
    for (int i = 0; i < 32; i++) begin
      send_sample(-16'sd32768, -1, 1'b0, got);
      if (i >= NT - 1) check_eq("dc_neg", got, -32768);
    end

    send_sample(16'sd1234, 5, 1'b0, got);
    check_eq("overrun_set", 32'(overrun), 1);
    send_sample(-16'sd777, 7, 1'b1, got);
    check_eq("overrun_set_beats_clear", 32'(overrun), 1);
    @(negedge clk);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check_eq("overrun_cleared", 32'(overrun), 0);

    for (int i = 0; i < 40; i++) send_sample(16'(i * 100), -1, 1'b0, got);

    for (int i = 0; i < 24; i++)
      send_sample(16'($urandom_range(0, 65535)), -1, 1'b0, got);
    check_eq("out_sample_held", out_sample, got);

    // Abort a computation with an asynchronous reset 8 cycles after the accept.
    wait_ready();
    in_sample = 16'sd20000;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midmac_in_ready", 32'(in_ready), 1);
    check_eq("midmac_out_valid", 32'(out_valid), 0);
    check_eq("midmac_out_sample", out_sample, 0);
    check_eq("midmac_state", 32'(state_o), 32'(ST_IDLE));
    n_v = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) n_v++;
    end
    rst = 1'b0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (out_valid) n_v++;
    end
    check_eq("midmac_no_output", n_v, 0);
    check_eq("midmac_out_sample_after", out_sample, 0);
    hist.delete();
    exp_q.delete();

    run_impulse("impulse_after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sample_lowpass_fir.md
SAMPLE_LOWPASS_FIR -- requirements
Module: sample_lowpass_fir

Interface
REQ-001 SHALL have parameter N_TAPS, default 16, meaning number of FIR taps (power of two, 4..64).
REQ-002 SHALL have parameter COEF_FRAC, default 15, meaning coefficient fractional bits (Q1.15).
REQ-003 SHALL have port clk  input  1  clock (mclk domain, 256x sample rate).
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port in_sample  input  16  signed PCM sample from the volume-adjusted source.
REQ-006 SHALL have port in_valid  input  1  in_sample qualifier, one-cycle strobe per sample.
REQ-007 SHALL have port in_ready  output  1  high when a new sample can be accepted.
REQ-008 SHALL have port out_sample  output  16  signed filtered sample, held between results.
REQ-009 SHALL have port out_valid  output  1  one-cycle strobe, out_sample updated this cycle.
REQ-010 SHALL have port overrun  output  1  sticky flag: a sample arrived while busy.
REQ-011 SHALL have port clear_overrun  input  1  synchronous clear of overrun.

Function
REQ-012 SHALL implement FSM states IDLE, MAC, ROUND, OUTPUT; IDLE->MAC on accept, MAC->ROUND after N_TAPS MAC cycles, ROUND->OUTPUT, OUTPUT->IDLE unconditionally.
REQ-013 SHALL assert in_ready only in IDLE; accept = in_valid && in_ready at a rising clk edge.
REQ-014 On accept SHALL write in_sample to circular buffer at write pointer wp, increment wp modulo N_TAPS, clear accumulator, and reset tap index to 0.
REQ-015 In MAC SHALL perform one product per cycle: acc += buf[(newest - i) mod N_TAPS] * COEFS[i], i = 0..N_TAPS-1, newest = entry written on accept.
REQ-016 Accumulator SHALL be signed, width 32 + clog2(N_TAPS) bits; no intermediate overflow permitted.
REQ-017 ROUND SHALL compute (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, then saturate to [-32768, 32767], registered into out_sample.
REQ-018 out_valid SHALL be high exactly during OUTPUT; latency from accept edge to out_valid high = N_TAPS + 2 cycles.
REQ-019 in_valid while in_ready low SHALL be dropped (buffer, wp, acc unchanged) and SHALL set overrun.
REQ-020 clear_overrun SHALL clear overrun next edge; simultaneous set and clear SHALL leave overrun set.
REQ-021 wp wrap from N_TAPS-1 to 0 SHALL be seamless; sample order in buffer preserved across wrap.
REQ-022 Before N_TAPS samples accepted after reset, unfilled entries SHALL contribute as zero.

Reset
REQ-023 rst SHALL asynchronously force: state IDLE, in_ready 1, out_sample 0, out_valid 0, overrun 0, wp 0, acc 0, tap index 0, all buffer entries 0.
REQ-024 rst asserted mid-MAC SHALL abort the computation with no out_valid produced; first accept after release starts a clean computation.

Structure
REQ-025 Shared package audio_pkg SHALL hold sample_t (signed 16), the default N_TAPS, COEF_FRAC, and LPF_COEFS (symmetric Q1.15 lowpass, all taps positive, sum exactly 32768 for unity DC gain).
REQ-026 Round-and-saturate SHALL be a separate combinational sub-module sample_round_sat (inputs acc, output sample_t), reusable by mixer stages.
REQ-027 Block SHALL sit between volume_adjust output and the audio output path, replacing a direct connection.

Verification
REQ-028 Impulse: one sample -32768 then N_TAPS-1 zeros, each spaced 256 cycles -> out_sample sequence equals -LPF_COEFS[0..N_TAPS-1] exactly.
REQ-029 DC: 32 samples of 32767 -> from the N_TAPS-th output onward out_sample = 32767; with -32768 -> -32768.
REQ-030 Latency/handshake: accept at cycle t -> in_ready low t+1..t+N_TAPS+2, out_valid high only at cycle t+N_TAPS+2, in_ready high next cycle.
REQ-031 Overrun: in_valid pulsed 5 cycles after accept -> sample dropped, overrun = 1, output identical to no-pulse run; clear_overrun -> overrun 0.
REQ-032 Reset mid-MAC: rst asserted 8 cycles after accept -> out_valid never pulses, out_sample 0, in_ready 1; subsequent impulse test passes unchanged.
REQ-033 Wrap: 40 accepted ramp samples (0, 100, 200, ...) -> each output matches a bench reference model bit-exactly across wp wrap.
